// File: rtl/frame_sequencer.sv
// Frame walker for the 3x3 edge-detection datapath: fetches each interior pixel's
// window, kicks one filter operation, and stores the result.
module frame_sequencer #(
  parameter int ADDRWIDTH = 32,
  parameter int DIMWIDTH  = 12
) (
  input  logic                 ahb_hclk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DIMWIDTH-1:0]  width,
  input  logic [DIMWIDTH-1:0]  height,
  input  logic [ADDRWIDTH-1:0] readStartAddress,
  input  logic [ADDRWIDTH-1:0] writeStartAddress,
  output logic                 read_req,
  output logic [ADDRWIDTH-1:0] read_addr,
  input  logic                 read_ack,
  output logic [3:0]           win_idx,
  output logic                 proc_start,
  input  logic                 proc_done,
  output logic                 write_req,
  output logic [ADDRWIDTH-1:0] write_addr,
  input  logic                 write_ack,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 dim_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_PSTART, S_PWAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [DIMWIDTH-1:0]  D_ONE   = DIMWIDTH'(1);
  localparam logic [DIMWIDTH-1:0]  D_TWO   = DIMWIDTH'(2);
  localparam logic [DIMWIDTH-1:0]  D_THREE = DIMWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] A_ONE   = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] A_TWO   = ADDRWIDTH'(2);

  state_t                 state_reg, state_next;
  logic [DIMWIDTH-1:0]    w_reg, w_next;
  logic [DIMWIDTH-1:0]    h_reg, h_next;
  logic [DIMWIDTH-1:0]    row_reg, row_next;
  logic [DIMWIDTH-1:0]    col_reg, col_next;
  logic [ADDRWIDTH-1:0]   rbase_reg, rbase_next;
  logic [ADDRWIDTH-1:0]   wbase_reg, wbase_next;
  logic [3:0]             win_reg, win_next;
  logic                   dim_err_reg, dim_err_next;

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= S_IDLE;
      w_reg       <= '0;
      h_reg       <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      rbase_reg   <= '0;
      wbase_reg   <= '0;
      win_reg     <= '0;
      dim_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      w_reg       <= w_next;
      h_reg       <= h_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      rbase_reg   <= rbase_next;
      wbase_reg   <= wbase_next;
      win_reg     <= win_next;
      dim_err_reg <= dim_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    w_next       = w_reg;
    h_next       = h_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    rbase_next   = rbase_reg;
    wbase_next   = wbase_reg;
    win_next     = win_reg;
    dim_err_next = dim_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          w_next     = width;
          h_next     = height;
          rbase_next = readStartAddress;
          wbase_next = writeStartAddress;
          win_next   = '0;
          row_next   = D_ONE;
          col_next   = D_ONE;
          if (width < D_THREE || height < D_THREE) begin
            dim_err_next = 1'b1;
            state_next   = S_DONE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ: begin
        if (read_ack) begin
          if (win_reg == 4'd8) state_next = S_PSTART;
          else                 win_next   = win_reg + 4'd1;
        end
      end
      S_PSTART: state_next = S_PWAIT;
      S_PWAIT:  if (proc_done) state_next = S_WRITE;
      S_WRITE:  if (write_ack) state_next = S_NEXT;
      S_NEXT: begin
        win_next = '0;
        if (col_reg == w_reg - D_TWO) begin
          if (row_reg == h_reg - D_TWO) begin
            state_next = S_DONE;
          end else begin
            col_next   = D_ONE;
            row_next   = row_reg + D_ONE;
            state_next = S_READ;
          end
        end else begin
          col_next   = col_reg + D_ONE;
          state_next = S_READ;
        end
      end
      S_DONE: begin
        dim_err_next = 1'b0;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Window slot to row/column offset within the 3x3 neighbourhood.
  logic [1:0] dr, dc;
  always_comb begin
    dr = 2'd0;
    dc = 2'd0;
    case (win_reg)
      4'd0: begin dr = 2'd0; dc = 2'd0; end
      4'd1: begin dr = 2'd0; dc = 2'd1; end
      4'd2: begin dr = 2'd0; dc = 2'd2; end
      4'd3: begin dr = 2'd1; dc = 2'd0; end
      4'd4: begin dr = 2'd1; dc = 2'd1; end
      4'd5: begin dr = 2'd1; dc = 2'd2; end
      4'd6: begin dr = 2'd2; dc = 2'd0; end
      4'd7: begin dr = 2'd2; dc = 2'd1; end
      4'd8: begin dr = 2'd2; dc = 2'd2; end
      default: begin dr = 2'd0; dc = 2'd0; end
    endcase
  end

  logic [ADDRWIDTH-1:0] rd_row, rd_col, rd_calc, wr_calc;
  always_comb begin
    rd_row  = ADDRWIDTH'(row_reg) - A_ONE + ADDRWIDTH'(dr);
    rd_col  = ADDRWIDTH'(col_reg) - A_ONE + ADDRWIDTH'(dc);
    rd_calc = rbase_reg + rd_row * ADDRWIDTH'(w_reg) + rd_col;
    wr_calc = wbase_reg + (ADDRWIDTH'(row_reg) - A_ONE) * (ADDRWIDTH'(w_reg) - A_TWO)
            + ADDRWIDTH'(col_reg) - A_ONE;
  end

  // Addresses are driven only while their request is up, so idle/reset shows zero.
  assign read_req   = (state_reg == S_READ);
  assign write_req  = (state_reg == S_WRITE);
  assign read_addr  = read_req  ? rd_calc : '0;
  assign write_addr = write_req ? wr_calc : '0;
  assign win_idx    = win_reg;
  assign proc_start = (state_reg == S_PSTART);
  assign busy       = (state_reg != S_IDLE);
  assign frame_done = (state_reg == S_DONE);
  assign dim_err    = dim_err_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a cycle-indexed vector table for one 4x4 frame
// plus hand-written sequences for stalls, bad dimensions, wrap, reset and restart.
module tb_frame_sequencer;

  logic        ahb_hclk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] width = 12'd4;
  logic [11:0] height = 12'd4;
  logic [31:0] readStartAddress = 32'h1000;
  logic [31:0] writeStartAddress = 32'h2000;
  logic        read_req;
  logic [31:0] read_addr;
  logic        read_ack = 1'b1;
  logic [3:0]  win_idx;
  logic        proc_start;
  logic        proc_done = 1'b1;
  logic        write_req;
  logic [31:0] write_addr;
  logic        write_ack = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        dim_err;

  frame_sequencer dut (
    .ahb_hclk(ahb_hclk), .n_rst(n_rst), .start(start), .width(width), .height(height),
    .readStartAddress(readStartAddress), .writeStartAddress(writeStartAddress),
    .read_req(read_req), .read_addr(read_addr), .read_ack(read_ack), .win_idx(win_idx),
    .proc_start(proc_start), .proc_done(proc_done), .write_req(write_req),
    .write_addr(write_addr), .write_ack(write_ack), .busy(busy),
    .frame_done(frame_done), .dim_err(dim_err)
  );

  always #5 ahb_hclk = ~ahb_hclk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] s_rr [0:255];
  logic [31:0] s_ra [0:255];
  logic [31:0] s_wi [0:255];
  logic [31:0] s_wr [0:255];
  logic [31:0] s_wa [0:255];
  logic [31:0] s_ps [0:255];
  logic [31:0] s_bs [0:255];
  logic [31:0] s_fd [0:255];
  logic [31:0] s_de [0:255];

  typedef struct {
    int          cyc;
    logic [31:0] rr, ra, wi, wr, wa, ps, bs, fd, de;
  } vec_t;
  vec_t vtab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'(read_req) | 32'(|read_addr) | 32'(win_idx) | 32'(proc_start) |
           32'(write_req) | 32'(|write_addr) | 32'(busy) | 32'(frame_done) | 32'(dim_err);
  endfunction

  task automatic do_reset();
    @(negedge ahb_hclk);
    n_rst = 1'b0;
    start = 1'b0;
    @(negedge ahb_hclk);
    @(negedge ahb_hclk);
    n_rst = 1'b1;
  endtask

  // Start a frame at edge 0 and record outputs mid-cycle for cycles 1..ncyc.
  task automatic run_frame(input int ncyc, input int hold, input int ra_from, input int ra_n,
                           input int pd_from, input int pd_n, input int wa_from, input int wa_n,
                           input int chg_cyc, input int chg_w);
    start = 1'b1;
    @(posedge ahb_hclk);
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      read_ack  = !(k >= ra_from && k < ra_from + ra_n);
      proc_done = !(k >= pd_from && k < pd_from + pd_n);
      write_ack = !(k >= wa_from && k < wa_from + wa_n);
      if (hold == 0) start = 1'b0;
      if (k == chg_cyc) width = chg_w[11:0];
      @(negedge ahb_hclk);
      s_rr[k] = 32'(read_req);  s_ra[k] = read_addr;       s_wi[k] = 32'(win_idx);
      s_wr[k] = 32'(write_req); s_wa[k] = write_addr;      s_ps[k] = 32'(proc_start);
      s_bs[k] = 32'(busy);      s_fd[k] = 32'(frame_done); s_de[k] = 32'(dim_err);
      @(posedge ahb_hclk);
    end
    start = 1'b0; read_ack = 1'b1; proc_done = 1'b1; write_ack = 1'b1;
  endtask

  function automatic int first_fd(input int ncyc);
    for (int k = 1; k <= ncyc; k++) if (s_fd[k] == 32'd1) return k;
    return 0;
  endfunction

  function automatic int count_of(input int sel, input int ncyc);
    int n = 0;
    for (int k = 1; k <= ncyc; k++)
      if ((sel == 0 ? s_rr[k] : (sel == 1 ? s_wr[k] : s_fd[k])) == 32'd1) n++;
    return n;
  endfunction

  function automatic void addv(input int c, input logic [31:0] rr, input logic [31:0] ra,
                               input logic [31:0] wi, input logic [31:0] wr, input logic [31:0] wa,
                               input logic [31:0] ps, input logic [31:0] bs, input logic [31:0] fd);
    vec_t v;
    v.cyc = c; v.rr = rr; v.ra = ra; v.wi = wi; v.wr = wr; v.wa = wa;
    v.ps = ps; v.bs = bs; v.fd = fd; v.de = 32'd0;
    vtab.push_back(v);
  endfunction

  initial begin
    // cycle, read_req, read_addr, win_idx, write_req, write_addr, proc_start, busy, frame_done
    addv(1,  1, 32'h1000, 0, 0, 0, 0, 1, 0);
    addv(2,  1, 32'h1001, 1, 0, 0, 0, 1, 0);
    addv(3,  1, 32'h1002, 2, 0, 0, 0, 1, 0);
    addv(4,  1, 32'h1004, 3, 0, 0, 0, 1, 0);
    addv(5,  1, 32'h1005, 4, 0, 0, 0, 1, 0);
    addv(6,  1, 32'h1006, 5, 0, 0, 0, 1, 0);
    addv(7,  1, 32'h1008, 6, 0, 0, 0, 1, 0);
    addv(8,  1, 32'h1009, 7, 0, 0, 0, 1, 0);
    addv(9,  1, 32'h100A, 8, 0, 0, 0, 1, 0);
    addv(10, 0, 0,        0, 0, 0, 1, 1, 0);
    addv(11, 0, 0,        0, 0, 0, 0, 1, 0);
    addv(12, 0, 0,        0, 1, 32'h2000, 0, 1, 0);
    addv(13, 0, 0,        0, 0, 0, 0, 1, 0);
    addv(14, 1, 32'h1001, 0, 0, 0, 0, 1, 0);
    addv(22, 1, 32'h100B, 8, 0, 0, 0, 1, 0);
    addv(25, 0, 0,        0, 1, 32'h2001, 0, 1, 0);
    addv(27, 1, 32'h1004, 0, 0, 0, 0, 1, 0);
    addv(38, 0, 0,        0, 1, 32'h2002, 0, 1, 0);
    addv(40, 1, 32'h1005, 0, 0, 0, 0, 1, 0);
    addv(48, 1, 32'h100F, 8, 0, 0, 0, 1, 0);
    addv(51, 0, 0,        0, 1, 32'h2003, 0, 1, 0);
    addv(53, 0, 0,        0, 0, 0, 0, 1, 1);
    addv(54, 0, 0,        0, 0, 0, 0, 0, 0);

    // Reset values
    n_rst = 1'b0;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    do_reset();

    // 4x4 frame, zero-wait handshakes, table-driven
    run_frame(56, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vtab[i]) begin
      int c;
      c = vtab[i].cyc;
      $display("vec cyc=%0d rr=%0d ra=0x%08h wi=%0d wr=%0d wa=0x%08h ps=%0d bs=%0d fd=%0d",
               c, s_rr[c], s_ra[c], s_wi[c], s_wr[c], s_wa[c], s_ps[c], s_bs[c], s_fd[c]);
      chk($sformatf("c%0d_read_req", c), s_rr[c], vtab[i].rr);
      chk($sformatf("c%0d_write_req", c), s_wr[c], vtab[i].wr);
      chk($sformatf("c%0d_proc_start", c), s_ps[c], vtab[i].ps);
      chk($sformatf("c%0d_busy", c), s_bs[c], vtab[i].bs);
      chk($sformatf("c%0d_frame_done", c), s_fd[c], vtab[i].fd);
      chk($sformatf("c%0d_dim_err", c), s_de[c], vtab[i].de);
      if (vtab[i].rr == 32'd1) begin
        chk($sformatf("c%0d_read_addr", c), s_ra[c], vtab[i].ra);
        chk($sformatf("c%0d_win_idx", c), s_wi[c], vtab[i].wi);
      end
      if (vtab[i].wr == 32'd1) chk($sformatf("c%0d_write_addr", c), s_wa[c], vtab[i].wa);
    end
    chk("base_fd_cycle", 32'(first_fd(56)), 32'd53);
    chk("base_write_count", 32'(count_of(1, 56)), 32'd4);
    chk("base_read_count", 32'(count_of(0, 56)), 32'd36);

    // read_ack low for 3 cycles at win_idx=4
    do_reset();
    run_frame(60, 0, 5, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 5; k <= 8; k++) begin
      chk($sformatf("stall_c%0d_rr", k), s_rr[k], 32'd1);
      chk($sformatf("stall_c%0d_ra", k), s_ra[k], 32'h1005);
      chk($sformatf("stall_c%0d_wi", k), s_wi[k], 32'd4);
    end
    chk("stall_c9_ra", s_ra[9], 32'h1006);
    chk("stall_fd_cycle", 32'(first_fd(60)), 32'd56);
    $display("read stall frame: frame_done at cycle %0d", first_fd(60));

    // proc_done low 2 cycles, write_ack low 1 cycle on the first pixel
    do_reset();
    run_frame(60, 0, 0, 0, 11, 2, 14, 1, 0, 0);
    chk("pw_c10_ps", s_ps[10], 32'd1);
    chk("pw_c11_ps", s_ps[11], 32'd0);
    chk("pw_c13_wr", s_wr[13], 32'd0);
    chk("pw_c14_wr", s_wr[14], 32'd1);
    chk("pw_c14_wa", s_wa[14], 32'h2000);
    chk("pw_c15_wa", s_wa[15], 32'h2000);
    chk("pw_c16_wr", s_wr[16], 32'd0);
    chk("pw_c17_ra", s_ra[17], 32'h1001);
    chk("pw_fd_cycle", 32'(first_fd(60)), 32'd56);
    $display("proc/write stall frame: frame_done at cycle %0d", first_fd(60));

    // Invalid dimensions
    do_reset();
    width = 12'd2; height = 12'd10;
    run_frame(12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dim_c1_fd", s_fd[1], 32'd1);
    chk("dim_c1_de", s_de[1], 32'd1);
    chk("dim_c1_bs", s_bs[1], 32'd1);
    chk("dim_c2_de", s_de[2], 32'd0);
    chk("dim_c2_bs", s_bs[2], 32'd0);
    chk("dim_reads", 32'(count_of(0, 12)), 32'd0);
    chk("dim_writes", 32'(count_of(1, 12)), 32'd0);
    $display("bad dims frame: frame_done=%0d dim_err=%0d", s_fd[1], s_de[1]);

    // Read address wrap
    do_reset();
    width = 12'd3; height = 12'd3;
    readStartAddress = 32'hFFFF_FFFE; writeStartAddress = 32'h3000;
    run_frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_c2_ra", s_ra[2], 32'hFFFF_FFFF);
    chk("wrap_c3_ra", s_ra[3], 32'h0000_0000);
    chk("wrap_c4_ra", s_ra[4], 32'h0000_0001);
    chk("wrap_writes", 32'(count_of(1, 16)), 32'd1);
    chk("wrap_c12_wa", s_wa[12], 32'h3000);
    chk("wrap_fd_cycle", 32'(first_fd(16)), 32'd14);
    $display("wrap frame: win2 addr=0x%08h write=0x%08h", s_ra[3], s_wa[12]);

    // Reset during PWAIT of pixel 2, then restart
    do_reset();
    width = 12'd4; height = 12'd4;
    readStartAddress = 32'h1000; writeStartAddress = 32'h2000;
    start = 1'b1;
    @(posedge ahb_hclk);
    #1 start = 1'b0;
    repeat (23) @(posedge ahb_hclk);
    @(negedge ahb_hclk);
    chk("rst_pwait_busy", 32'(busy), 32'd1);
    chk("rst_pwait_win", 32'(win_idx), 32'd8);
    n_rst = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 32'd0);
    @(negedge ahb_hclk);
    chk("rst_held_fd", 32'(frame_done), 32'd0);
    n_rst = 1'b1;
    start = 1'b1;
    @(posedge ahb_hclk);
    #1 start = 1'b0;
    @(negedge ahb_hclk);
    chk("restart_rr", 32'(read_req), 32'd1);
    chk("restart_ra", read_addr, 32'h1000);
    chk("restart_wi", 32'(win_idx), 32'd0);
    @(negedge ahb_hclk);
    chk("restart_ra2", read_addr, 32'h1001);
    $display("reset/restart: read_addr=0x%08h", read_addr);

    // Width changes mid-frame with start held; next frame picks up W=8
    do_reset();
    width = 12'd4; height = 12'd4;
    run_frame(60, 1, 0, 0, 0, 0, 0, 0, 5, 8);
    chk("chg_c27_ra", s_ra[27], 32'h1004);
    chk("chg_c48_ra", s_ra[48], 32'h100F);
    chk("chg_fd_cycle", 32'(first_fd(60)), 32'd53);
    chk("chg_fd_count", 32'(count_of(2, 60)), 32'd1);
    chk("chg_c54_bs", s_bs[54], 32'd0);
    chk("chg_c55_rr", s_rr[55], 32'd1);
    chk("chg_c55_ra", s_ra[55], 32'h1000);
    chk("chg_c58_ra", s_ra[58], 32'h1008);
    $display("width change: frame2 win3 addr=0x%08h", s_ra[58]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
